// File: rtl/sc_config_regbank_pkg.sv
// sc_config_pkg: shared constants and address helpers for the scan-converter
// configuration register bank.
package sc_config_pkg;

  localparam int REG_W        = 32;
  localparam int BE_W         = REG_W / 8;
  localparam int CNT_W        = 8;
  localparam int CTRL_ADDR    = 0;
  localparam int CTRL_APPLY   = 0;
  localparam int CTRL_IMMED   = 1;
  localparam int CTRL_CANCEL  = 2;
  localparam int CTRL_CNT_LSB = 8;

  function automatic int status_addr(input int i);
    return 1 + i;
  endfunction

  function automatic int config_addr(input int k, input int num_status);
    return num_status + 1 + k;
  endfunction

  // Byte-lane merge: lanes with a set enable take new data, others keep the old word.
  function automatic logic [REG_W-1:0] be_merge(input logic [REG_W-1:0] old_w,
                                                input logic [REG_W-1:0] new_w,
                                                input logic [BE_W-1:0]  be);
    logic [REG_W-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sc_config_regbank_if.sv
// sc_config_regbank_if: Avalon-MM slave bus bundle between the control CPU and
// the configuration register bank.
interface sc_config_regbank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              write;
  logic              read;
  logic              chipselect;
  logic              waitrequest_n;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, writedata, byteenable, write, read, chipselect,
    input  waitrequest_n, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, byteenable, write, read, chipselect,
    output waitrequest_n, readdata, readdatavalid
  );
endinterface

// File: rtl/sc_config_regbank_dbreg.sv
// sc_config_dbreg: one byte-enabled shadow/active register pair. The shadow
// takes CPU writes; the active copy loads from the shadow on apply.
module sc_config_dbreg
  import sc_config_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_wr_en,
  input  logic [REG_W-1:0] i_wdata,
  input  logic [BE_W-1:0]  i_be,
  input  logic             i_immediate,
  input  logic             i_apply,
  output logic [REG_W-1:0] o_shadow,
  output logic [REG_W-1:0] o_active
);

  logic [REG_W-1:0] r_shadow;
  logic [REG_W-1:0] r_active;
  logic [REG_W-1:0] w_merged;

  assign w_merged = be_merge(r_shadow, i_wdata, i_be);

  // Shadow word: byte-merged CPU writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shadow <= '0;
    end else if (i_wr_en) begin
      r_shadow <= w_merged;
    end
  end

  // Active word: an apply takes the pre-write shadow and outranks an immediate bypass.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_active <= '0;
    end else if (i_apply) begin
      r_active <= r_shadow;
    end else if (i_wr_en && i_immediate) begin
      r_active <= w_merged;
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;

endmodule

// File: rtl/sc_config_regbank.sv
// sc_config_regbank: Avalon-MM register bank with double-buffered config words
// applied on frame boundaries. Build option SC_CONFIG_READBACK_EN enables shadow readback.
module sc_config_regbank
  import sc_config_pkg::*;
#(
  parameter int NUM_STATUS = 3,
  parameter int NUM_CONFIG = 10,
  parameter int ADDR_W     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  sc_config_regbank_if.slave          avalon_s,
  input  logic [REG_W*NUM_STATUS-1:0] status_i,
  input  logic                        frame_strobe_i,
  output logic [REG_W*NUM_CONFIG-1:0] config_o,
  output logic                        apply_pending_o,
  output logic                        apply_done_o
);

  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CTRL_ADDR);

  if ((NUM_STATUS < 1) || (NUM_STATUS > 15) || (NUM_CONFIG < 1) || (NUM_CONFIG > 32)) begin : g_param_check
    $error("sc_config_regbank: NUM_STATUS or NUM_CONFIG out of range");
  end

  if (1 + NUM_STATUS + NUM_CONFIG > 2**ADDR_W) begin : g_addr_check
    $error("sc_config_regbank: register map does not fit in ADDR_W");
  end

  logic                        w_wr_acc;
  logic                        w_rd_acc;
  logic                        w_ctrl_wr;
  logic                        w_set_req;
  logic                        w_cancel_req;
  logic                        w_apply;
  logic [NUM_CONFIG-1:0]       w_cfg_wr;
  logic [REG_W*NUM_CONFIG-1:0] w_shadow_flat;
  logic [REG_W-1:0]            w_ctrl_word;
  logic [REG_W-1:0]            w_rd_mux;

  logic                        r_pending;
  logic                        r_immediate;
  logic                        r_apply_done;
  logic [CNT_W-1:0]            r_apply_cnt;
  logic                        r_rdvalid;
  logic [REG_W-1:0]            r_rdata;

  assign w_wr_acc     = avalon_s.chipselect & avalon_s.write;
  assign w_rd_acc     = avalon_s.chipselect & avalon_s.read;
  assign w_ctrl_wr    = w_wr_acc & (avalon_s.address == CTRL_A) & avalon_s.byteenable[0];
  assign w_set_req    = w_ctrl_wr & avalon_s.writedata[CTRL_APPLY];
  assign w_cancel_req = w_ctrl_wr & avalon_s.writedata[CTRL_CANCEL];
  // Only a request already registered before the strobe edge can trigger an apply.
  assign w_apply      = frame_strobe_i & r_pending;

  for (genvar k = 0; k < NUM_CONFIG; k++) begin : g_cfg
    localparam logic [ADDR_W-1:0] CFG_A = ADDR_W'(config_addr(k, NUM_STATUS));

    assign w_cfg_wr[k] = w_wr_acc & (avalon_s.address == CFG_A);

    sc_config_dbreg u_dbreg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_wr_en     (w_cfg_wr[k]),
      .i_wdata     (avalon_s.writedata),
      .i_be        (avalon_s.byteenable),
      .i_immediate (r_immediate),
      .i_apply     (w_apply),
      .o_shadow    (w_shadow_flat[REG_W*k +: REG_W]),
      .o_active    (config_o[REG_W*k +: REG_W])
    );
  end

  // Pending flag: cancel beats set, and a fresh set survives a coincident apply.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= 1'b0;
    end else if (w_cancel_req) begin
      r_pending <= 1'b0;
    end else if (w_set_req) begin
      r_pending <= 1'b1;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end
  end

  // IMMEDIATE mode bit, apply counter and the apply-done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_immediate  <= 1'b0;
      r_apply_cnt  <= '0;
      r_apply_done <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_immediate <= avalon_s.writedata[CTRL_IMMED];
      end
      if (w_apply) begin
        r_apply_cnt <= r_apply_cnt + 8'd1;
      end
      r_apply_done <= w_apply;
    end
  end

  // CTRL readback word assembly.
  always_comb begin
    w_ctrl_word                         = '0;
    w_ctrl_word[CTRL_APPLY]             = r_pending;
    w_ctrl_word[CTRL_IMMED]             = r_immediate;
    w_ctrl_word[CTRL_CNT_LSB +: CNT_W]  = r_apply_cnt;
  end

  // Read mux: address hits are one-hot, so the selected words are OR-combined.
  always_comb begin
    w_rd_mux = (avalon_s.address == CTRL_A) ? w_ctrl_word : '0;
    for (int i = 0; i < NUM_STATUS; i++) begin
      w_rd_mux = w_rd_mux | ((avalon_s.address == ADDR_W'(status_addr(i)))
                             ? status_i[REG_W*i +: REG_W] : '0);
    end
`ifdef SC_CONFIG_READBACK_EN
    for (int k = 0; k < NUM_CONFIG; k++) begin
      w_rd_mux = w_rd_mux | ((avalon_s.address == ADDR_W'(config_addr(k, NUM_STATUS)))
                             ? w_shadow_flat[REG_W*k +: REG_W] : '0);
    end
`endif
  end

`ifndef SC_CONFIG_READBACK_EN
  logic w_unused_shadow;
  assign w_unused_shadow = ^w_shadow_flat;
`endif

  // Read data register: one-cycle latency, zero whenever not qualified.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdvalid <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rdvalid <= w_rd_acc;
      r_rdata   <= w_rd_acc ? w_rd_mux : '0;
    end
  end

  assign avalon_s.waitrequest_n = 1'b1;
  assign avalon_s.readdata      = r_rdata;
  assign avalon_s.readdatavalid = r_rdvalid;
  assign apply_pending_o        = r_pending;
  assign apply_done_o           = r_apply_done;

endmodule

// File: tb/tb_sc_config_regbank.sv
// Self-checking bench for sc_config_regbank: directed scenarios plus random
// traffic against a register-map reference model, with a read-data scoreboard.
module tb_sc_config_regbank;

  localparam int NS = 3;
  localparam int NC = 10;
  localparam int AW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [32*NS-1:0]  status_i = '0;
  logic              frame_strobe_i = 1'b0;
  logic [32*NC-1:0]  config_o;
  logic              apply_pending_o;
  logic              apply_done_o;

  sc_config_regbank_if #(.ADDR_W(AW)) avs();

  sc_config_regbank #(.NUM_STATUS(NS), .NUM_CONFIG(NC), .ADDR_W(AW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .avalon_s        (avs),
    .status_i        (status_i),
    .frame_strobe_i  (frame_strobe_i),
    .config_o        (config_o),
    .apply_pending_o (apply_pending_o),
    .apply_done_o    (apply_done_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  // Reference model state: the register map as the CPU sees it.
  logic [31:0] m_shadow[NC];
  logic [31:0] m_active[NC];
  bit          m_pending;
  bit          m_immed;
  bit          m_done;
  int          m_count;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_shadow[i] = 32'h0;
      m_active[i] = 32'h0;
    end
    m_pending = 1'b0;
    m_immed   = 1'b0;
    m_done    = 1'b0;
    m_count   = 0;
  endtask

  function automatic logic [32*NC-1:0] model_config();
    logic [32*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[32*i +: 32] = m_active[i];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = 32'h0;
    if (a == 0) begin
      v[0]    = m_pending;
      v[1]    = m_immed;
      v[15:8] = 8'(m_count % 256);
    end else if (a >= 1 && a <= NS) begin
      v = status_i[32*(a-1) +: 32];
    end else if (a >= NS + 1 && a < NS + 1 + NC) begin
`ifdef SC_CONFIG_READBACK_EN
      v = m_shadow[a-NS-1];
`else
      v = 32'h0;
`endif
    end
    return v;
  endfunction

  // One bus cycle, driven from a falling edge; model advances at the rising edge.
  task automatic bus_cycle(input bit wr, input bit rd, input int a,
                           input logic [31:0] data, input logic [3:0] be, input bit strobe);
    bit          apply;
    bit          np;
    bit          ni;
    int          k;
    logic [31:0] merged;
    logic [31:0] nsh[NC];
    logic [31:0] nac[NC];

    status_i        = {$urandom, $urandom, $urandom};
    avs.chipselect  = wr | rd;
    avs.write       = wr;
    avs.read        = rd;
    avs.address     = AW'(a);
    avs.writedata   = data;
    avs.byteenable  = be;
    frame_strobe_i  = strobe;

    if (rd) exp_q.push_back(model_read(a));

    apply = strobe && m_pending;
    for (int i = 0; i < NC; i++) begin
      nsh[i] = m_shadow[i];
      nac[i] = apply ? m_shadow[i] : m_active[i];
    end
    if (wr && a >= NS + 1 && a < NS + 1 + NC) begin
      k = a - NS - 1;
      merged = m_shadow[k];
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = data[8*b +: 8];
      nsh[k] = merged;
      if (m_immed && !apply) nac[k] = merged;
    end
    np = apply ? 1'b0 : m_pending;
    ni = m_immed;
    if (wr && a == 0 && be[0]) begin
      ni = data[1];
      if (data[2]) np = 1'b0;
      else if (data[0]) np = 1'b1;
    end

    @(posedge clk_i);
    for (int i = 0; i < NC; i++) begin
      m_shadow[i] = nsh[i];
      m_active[i] = nac[i];
    end
    m_pending = np;
    m_immed   = ni;
    m_done    = apply;
    if (apply) m_count++;

    @(negedge clk_i);
    check("config_o", 512'(config_o), 512'(model_config()));
    check("apply_done_o", 512'(apply_done_o), 512'(m_done));
    check("apply_pending_o", 512'(apply_pending_o), 512'(m_pending));
    check("readdatavalid", 512'(avs.readdatavalid), 512'(rd));
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d, input logic [3:0] be);
    bus_cycle(1'b1, 1'b0, a, d, be, 1'b0);
  endtask

  task automatic rd_reg(input int a);
    bus_cycle(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic strobe();
    bus_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
  endtask

  // Scoreboard monitor: every valid read word pops one expectation.
  always @(negedge clk_i) begin : mon
    logic [31:0] e;
    if (!rst_i) begin
      if (avs.readdatavalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got data %0h, expected no read response", avs.readdata);
        end else begin
          e = exp_q.pop_front();
          check("readdata", 512'(avs.readdata), 512'(e));
        end
      end else begin
        check("readdata_idle", 512'(avs.readdata), 512'(0));
      end
    end
  end

  initial begin
    int op;
    int a;
    avs.chipselect = 1'b0;
    avs.write      = 1'b0;
    avs.read       = 1'b0;
    avs.address    = '0;
    avs.writedata  = 32'h0;
    avs.byteenable = 4'h0;
    model_reset();

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_config_o", 512'(config_o), 512'(0));
    check("rst_pending", 512'(apply_pending_o), 512'(0));
    check("rst_done", 512'(apply_done_o), 512'(0));
    check("rst_rdvalid", 512'(avs.readdatavalid), 512'(0));
    check("waitrequest_n", 512'(avs.waitrequest_n), 512'(1));

    rd_reg(0); rd_reg(4); rd_reg(15);
    idle(1);

    wr_reg(4, 32'hDEADBEEF, 4'b0011);
    rd_reg(4);
    wr_reg(0, 32'h1, 4'h1);
    strobe();
    idle(1);
    rd_reg(0);

    bus_cycle(1'b1, 1'b0, 0, 32'h1, 4'h1, 1'b1);
    strobe();
    rd_reg(0);

    wr_reg(0, 32'h2, 4'h1);
    wr_reg(13, 32'h12345678, 4'hF);
    rd_reg(0);
    rd_reg(13);
    wr_reg(0, 32'h0, 4'h1);

    for (int i = 0; i < 256; i++) begin
      wr_reg(0, 32'h1, 4'h1);
      strobe();
    end
    rd_reg(0);
    wr_reg(0, 32'h1, 4'h1);
    wr_reg(0, 32'h5, 4'h1);
    strobe();
    rd_reg(0);

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 15);
      if (op <= 3)
        bus_cycle(1'b1, 1'b0, a, $urandom, 4'($urandom), ($urandom_range(0, 5) == 0));
      else if (op <= 6)
        bus_cycle(1'b0, 1'b1, a, 32'h0, 4'h0, ($urandom_range(0, 5) == 0));
      else if (op == 7)
        bus_cycle(1'b1, 1'b0, 0, $urandom, 4'($urandom), ($urandom_range(0, 5) == 0));
      else
        bus_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, ($urandom_range(0, 3) == 0));
    end

    wr_reg(5, 32'hA5A5A5A5, 4'hF);
    wr_reg(0, 32'h1, 4'h1);
    idle(1);
    avs.chipselect = 1'b0;
    avs.write      = 1'b0;
    avs.read       = 1'b0;
    rst_i = 1'b1;
    #2;
    model_reset();
    check("midrst_config_o", 512'(config_o), 512'(0));
    check("midrst_pending", 512'(apply_pending_o), 512'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    strobe();
    rd_reg(0);
    rd_reg(5);
    idle(2);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_missing: got %0d outstanding reads, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_config_regbank.md
# sc_config_regbank

Parametrised Avalon-MM register bank between the Nios II control CPU and the scan converter datapath. It exposes NUM_STATUS read-only status words and NUM_CONFIG double-buffered 32-bit configuration words. CPU writes land in shadow registers. Shadow contents move to the active registers, which drive the datapath, only at a frame-boundary strobe after software requests it. This gives tear-free mode changes.

## Interface
Parameters:
- NUM_STATUS, 3, number of read-only status words (1..15)
- NUM_CONFIG, 10, number of configuration words (1..32)
- ADDR_W, 4, Avalon word-address width; 1+NUM_STATUS+NUM_CONFIG <= 2**ADDR_W is required (elaboration-time assertion)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- avalon_s_address  in  ADDR_W  word address
- avalon_s_writedata  in  32  write data
- avalon_s_byteenable  in  4  byte lanes
- avalon_s_write / avalon_s_read / avalon_s_chipselect  in  1 each  transfer qualifiers
- avalon_s_waitrequest_n  out  1  constant 1
- avalon_s_readdata  out  32  registered read data
- avalon_s_readdatavalid  out  1  read-data qualifier
- status_i  in  32*NUM_STATUS  packed status words; word i is [32*i+:32]
- frame_strobe_i  in  1  single-cycle frame-boundary pulse, synchronous to clk_i
- config_o  out  32*NUM_CONFIG  packed active configuration words
- apply_pending_o  out  1  apply requested, not yet performed
- apply_done_o  out  1  one-cycle pulse on the cycle after the active registers load

Reset is rst_i, asynchronous, active-high; clock is clk_i.

## Operation
- Address map:
  - 0 = CTRL.
  - 1..NUM_STATUS = status word (addr-1).
  - NUM_STATUS+1+k = config word k (shadow).
  - All other addresses are unmapped: read 0, writes ignored.
- Config write: byte-enabled merge into shadow[k] only.
- Status write: ignored.
- CTRL write (byte lane 0 only):
  - bit0 = 1 sets pending.
  - bit1 writes IMMEDIATE mode.
  - bit2 = 1 clears pending.
  - bit2 and bit0 both set in one write: cancel wins.
- CTRL read:
  - bit0 pending.
  - bit1 IMMEDIATE.
  - [15:8] apply_count, 8-bit, wraps 255 -> 0.
  - Other bits 0.
- Apply: frame_strobe_i while pending=1 triggers, on that edge:
  - active <= shadow for all words;
  - pending <= 0;
  - apply_count increments.
- IMMEDIATE=1: a config write updates shadow and active on the same edge with the merged value. Strobe-driven apply still works in this mode.
- Simultaneous events:
  - Apply request and strobe in the same cycle: no apply that cycle; pending=1 and the apply happens at the next strobe.
  - Shadow write and apply in the same cycle: active takes the pre-write shadow; the write stays in shadow.
  - Cancel and strobe in the same cycle while pending: the apply happens (pending was already 1).
- Shadow writes while pending are permitted; the latest shadow contents are applied.
- Reset values: all outputs, shadow, active, pending, IMMEDIATE and apply_count = 0. Reset mid-operation discards any pending apply.

## Timing
- Writes: zero wait states; the register updates on the edge that samples the write.
- Reads: fixed latency 1. avalon_s_readdatavalid=1 and readdata are valid on the cycle after chipselect&&read. At all other times readdata=0 and readdatavalid=0.
- Status words are sampled on the read-accept edge.
- config_o changes on the apply edge.
- apply_done_o is high on the cycle after the apply edge.
- apply_pending_o is combinationally equal to the pending register.

## Configuration
- SC_CONFIG_READBACK_EN defined: config addresses read the shadow value.
- SC_CONFIG_READBACK_EN undefined: config addresses read 0, and the readback mux is not synthesised.
- CTRL and status reads are identical in both builds.

## Structure
- Package sc_config_pkg:
  - REG_W=32;
  - CTRL bit positions (CTRL_APPLY=0, CTRL_IMMED=1, CTRL_CANCEL=2, CTRL_CNT_LSB=8);
  - functions status_addr(i) and config_addr(k, NUM_STATUS).
- Sub-module sc_config_dbreg: one 32-bit byte-enabled shadow/active pair with write, immediate and apply inputs. Instantiated NUM_CONFIG times via generate.
- Top level holds the address decode, CTRL logic, the read mux/register and apply_count.

## Test plan
Defaults apply (config k at address 4+k).
- Reset, then read addresses 0, 4 and 15 -> readdatavalid one cycle later with data 0; config_o all 0.
- Write 0xDEADBEEF to address 4 with byteenable 4'b0011 -> shadow[0]=0x0000BEEF; config_o word0 remains 0 until apply; readback 0x0000BEEF with the macro, 0 without.
- Write CTRL=1, then pulse frame_strobe_i -> config_o word0=0x0000BEEF on the strobe edge; apply_done_o pulses one cycle later; CTRL reads 0x00000100.
- CTRL=1 write in the same cycle as the strobe -> no apply; the next strobe applies; apply_count=1.
- Write CTRL=2, then write 0x12345678 to address 13 -> config_o word9=0x12345678 on the same edge; CTRL reads 0x00000002.
- Drive 256 apply cycles -> apply_count wraps to 0; CTRL write 0x5 while pending -> pending=0, and the next strobe does not apply.
